// File: rtl/expr_eval_if.sv
// expr_eval character-stream / result bundle.
// master drives the stream, slave is the evaluator.
interface expr_eval_if #(
  parameter int W       = 16,
  parameter int DEPTH_W = 4
);
  logic               en;
  logic [7:0]         in;
  logic               legal;
  logic [W-1:0]       value;
  logic [DEPTH_W-1:0] depth;
  logic               valid;
  logic               err;

  modport master (
    output en, in, legal,
    input  value, depth, valid, err
  );

  modport slave (
    input  en, in, legal,
    output value, depth, valid, err
  );
endinterface

// File: rtl/expr_eval.sv
// Incremental '+'/'*' expression evaluator with a parenthesis stack.
// Define EXPR_EVAL_MINUS_EN to accept '-' (per-level sign bit).
module expr_eval #(
  parameter int W       = 16,
  parameter int DEPTH   = 8,
  parameter int DEPTH_W = 4
) (
  input logic        clk,
  input logic        clr,
  expr_eval_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [DEPTH_W-1:0] DMAX = DEPTH_W'(DEPTH);

  typedef struct packed {
    logic [W-1:0] s;
    logic [W-1:0] t;
    logic         h;
`ifdef EXPR_EVAL_MINUS_EN
    logic         g;
`endif
  } lvl_t;

  logic [W-1:0]       s_q, s_d, t_q, t_d;
  logic               h_q, h_d, n_q, n_d;
  logic               err_q, err_d;
  logic [DEPTH_W-1:0] dp_q, dp_d;
  lvl_t               stk_q [DEPTH];
  lvl_t               stk_d [DEPTH];
  lvl_t               top;
  logic [AW-1:0]      wr_idx, rd_idx;
  logic [W-1:0]       term, cur, fac;
  logic               is_dig, is_mul, is_add, is_opn, is_cls;
`ifdef EXPR_EVAL_MINUS_EN
  logic               g_q, g_d, is_sub;
  assign is_sub = (bus.in == 8'h2D);
`endif

  assign is_dig = (bus.in >= 8'h30) && (bus.in <= 8'h39);
  assign is_mul = (bus.in == 8'h2A);
  assign is_add = (bus.in == 8'h2B);
  assign is_opn = (bus.in == 8'h28);
  assign is_cls = (bus.in == 8'h29);
  assign fac    = W'(bus.in[3:0]);
  assign wr_idx = AW'(dp_q);
  assign rd_idx = AW'(dp_q - 1'b1);
  assign top    = stk_q[rd_idx];
  assign term   = h_q ? t_q : '0;

`ifdef EXPR_EVAL_MINUS_EN
  assign cur = g_q ? s_q - term : s_q + term;
`else
  assign cur = s_q + term;
`endif

  always_comb begin
    s_d   = s_q;
    t_d   = t_q;
    h_d   = h_q;
    n_d   = n_q;
    dp_d  = dp_q;
    err_d = err_q;
    stk_d = stk_q;
`ifdef EXPR_EVAL_MINUS_EN
    g_d   = g_q;
`endif
    if (bus.en && !err_q) begin
      n_d = 1'b1;
      unique case (1'b1)
        is_dig: begin
          t_d = t_q * fac;
          h_d = 1'b1;
        end
        is_mul: ;
        is_add: begin
          s_d = cur;
          t_d = W'(1);
          h_d = 1'b0;
`ifdef EXPR_EVAL_MINUS_EN
          g_d = 1'b0;
`endif
        end
`ifdef EXPR_EVAL_MINUS_EN
        is_sub: begin
          s_d = cur;
          t_d = W'(1);
          h_d = 1'b0;
          g_d = 1'b1;
        end
`endif
        is_opn: begin
          if (dp_q == DMAX) begin
            err_d = 1'b1;
          end else begin
            stk_d[wr_idx].s = s_q;
            stk_d[wr_idx].t = t_q;
            stk_d[wr_idx].h = h_q;
`ifdef EXPR_EVAL_MINUS_EN
            stk_d[wr_idx].g = g_q;
            g_d = 1'b0;
`endif
            dp_d = dp_q + 1'b1;
            s_d  = '0;
            t_d  = W'(1);
            h_d  = 1'b0;
          end
        end
        is_cls: begin
          if (dp_q == '0) begin
            err_d = 1'b1;
          end else begin
            // closed group value becomes a factor of the outer term
            s_d  = top.s;
            t_d  = top.t * cur;
            h_d  = 1'b1;
`ifdef EXPR_EVAL_MINUS_EN
            g_d  = top.g;
`endif
            dp_d = dp_q - 1'b1;
          end
        end
        default: err_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      s_q   <= '0;
      t_q   <= W'(1);
      h_q   <= 1'b0;
      n_q   <= 1'b0;
      dp_q  <= '0;
      err_q <= 1'b0;
`ifdef EXPR_EVAL_MINUS_EN
      g_q   <= 1'b0;
`endif
    end else begin
      s_q   <= s_d;
      t_q   <= t_d;
      h_q   <= h_d;
      n_q   <= n_d;
      dp_q  <= dp_d;
      err_q <= err_d;
`ifdef EXPR_EVAL_MINUS_EN
      g_q   <= g_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    stk_q <= stk_d;
  end

  assign bus.value = cur;
  assign bus.depth = dp_q;
  assign bus.err   = err_q;
  assign bus.valid = bus.legal & n_q & (dp_q == '0) & ~err_q;
endmodule

// File: tb/tb_expr_eval.sv
// Scoreboarded random + directed bench for expr_eval (W=8, DEPTH=4).
// Model: per-level lists of closed terms and current-term factors.
module tb_expr_eval;
  localparam int WID  = 8;
  localparam int DEP  = 4;
  localparam int DW   = 3;
  localparam int MASK = (1 << WID) - 1;

  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  expr_eval_if #(.W(WID), .DEPTH_W(DW)) bus ();

  expr_eval #(.W(WID), .DEPTH(DEP), .DEPTH_W(DW)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  typedef struct {
    int value;
    int depth;
    bit valid;
    bit err;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  int facs  [DEP+1][$];
  int terms [DEP+1][$];
  bit neg   [DEP+1];
  int lvl;
  bit m_err, m_n;

  function automatic int prod(int l);
    int p = 1;
    for (int k = 0; k < facs[l].size(); k++)
      p = (p * facs[l][k]) & MASK;
    return p;
  endfunction

  function automatic int levelval(int l);
    int s = 0;
    for (int k = 0; k < terms[l].size(); k++)
      s += terms[l][k];
    if (facs[l].size() > 0)
      s += neg[l] ? -prod(l) : prod(l);
    return s & MASK;
  endfunction

  task automatic new_level(int l);
    facs[l].delete();
    terms[l].delete();
    neg[l] = 1'b0;
  endtask

  task automatic commit(bit nn);
    if (facs[lvl].size() > 0)
      terms[lvl].push_back(neg[lvl] ? -prod(lvl) : prod(lvl));
    facs[lvl].delete();
    neg[lvl] = nn;
  endtask

  task automatic model_step(byte c, bit e, bit rst);
    int v;
    if (rst) begin
      lvl = 0; m_err = 0; m_n = 0;
      new_level(0);
    end else if (e && !m_err) begin
      m_n = 1;
      if (c >= "0" && c <= "9") facs[lvl].push_back(int'(c) - 48);
      else if (c == "*") ;
      else if (c == "+") commit(1'b0);
`ifdef EXPR_EVAL_MINUS_EN
      else if (c == "-") commit(1'b1);
`endif
      else if (c == "(") begin
        if (lvl == DEP) m_err = 1;
        else begin lvl++; new_level(lvl); end
      end else if (c == ")") begin
        if (lvl == 0) m_err = 1;
        else begin
          v = levelval(lvl);
          lvl--;
          facs[lvl].push_back(v);
        end
      end else m_err = 1;
    end
  endtask

  task automatic send(byte c, bit e = 1, bit lg = 1, bit rst = 0);
    exp_t x;
    @(negedge clk);
    bus.en = e; bus.in = c; bus.legal = lg; clr = rst;
    model_step(c, e, rst);
    x.value = levelval(lvl);
    x.depth = lvl;
    x.err   = m_err;
    x.valid = lg && m_n && lvl == 0 && !m_err;
    sbq.push_back(x);
  endtask

  task automatic send_str(string s, bit lg = 1);
    for (int i = 0; i < s.len(); i++) send(s[i], 1'b1, lg, 1'b0);
  endtask

  task automatic chk(string nm, int got, int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", nm, got, want);
    end
  endtask

  task automatic settle();
    @(posedge clk); #3;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk); #2;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("sb_value", int'(bus.value), e.value);
        chk("sb_depth", int'(bus.depth), e.depth);
        chk("sb_valid", int'(bus.valid), int'(e.valid));
        chk("sb_err",   int'(bus.err),   int'(e.err));
      end
    end
  end

  initial begin : stim
    byte tbl [15];
    int  r;
    string cs;
    cs = "0123456789+*()x";
    for (int i = 0; i < 15; i++) tbl[i] = cs[i];
    bus.en = 0; bus.in = 8'h00; bus.legal = 0;

    send(8'h00, 0, 0, 1);
    send(8'h00, 0, 0, 1);
    settle();
    chk("rst_value", int'(bus.value), 0);
    chk("rst_valid", int'(bus.valid), 0);

    send_str("1+(1+2)*(3+2)");
    settle();
    chk("paren_value", int'(bus.value), 16);
    chk("paren_valid", int'(bus.valid), 1);
    send_str("2"); settle();
    chk("tail2_value", int'(bus.value), 31);
    send_str("2"); settle();
    chk("tail22_value", int'(bus.value), 61);

    send(8'h00, 0, 0, 1);
    send_str("1+(1+2)*(3+", 0);
    send("9", 1, 0, 1);
    settle();
    chk("midclr_value", int'(bus.value), 0);
    chk("midclr_depth", int'(bus.depth), 0);
    send_str("4*5"); settle();
    chk("after_clr_value", int'(bus.value), 20);

    send(8'h00, 0, 0, 1);
    send_str(")"); settle();
    chk("close0_err", int'(bus.err), 1);
    send_str("1+2"); settle();
    chk("sticky_value", int'(bus.value), 0);

    send(8'h00, 0, 0, 1);
    send_str("(((("); settle();
    chk("full_depth", int'(bus.depth), 4);
    send_str("("); settle();
    chk("over_err", int'(bus.err), 1);
    chk("over_depth", int'(bus.depth), 4);

    send(8'h00, 0, 0, 1);
    send_str("9*9*9"); settle();
    chk("wrap_value", int'(bus.value), 217);
    send(8'h00, 0, 0, 1);
    send_str("5+");
    for (int i = 0; i < 3; i++) send("7", 0, 0, 0);
    settle();
    chk("hold_value", int'(bus.value), 5);

    send(8'h00, 0, 0, 1);
    send_str("3-5"); settle();
`ifdef EXPR_EVAL_MINUS_EN
    chk("minus_value", int'(bus.value), 'hFE);
    send(8'h00, 0, 0, 1);
    send_str("2*(3-1)"); settle();
    chk("minus_paren", int'(bus.value), 4);
`else
    chk("minus_err", int'(bus.err), 1);
`endif

    for (int i = 0; i < 800; i++) begin
      r = $urandom_range(0, 99);
      if (r < 3) send(8'h00, 1, 0, 1);
      else if (r < 5) send("-", 1, 1'($urandom_range(0, 1)), 0);
      else send(tbl[$urandom_range(0, 14)],
                1'($urandom_range(0, 7) != 0),
                1'($urandom_range(0, 1)), 0);
    end

    send(8'h00, 0, 0, 0);
    settle();
    settle();
    chk("sb_drained", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
